// File: rtl/clock_div_multi_if.sv
// Configuration port of clock_div_multi: one half-period write per transfer,
// plus a one-cycle error pulse for writes aimed at a nonexistent channel.
interface clock_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = $clog2(NUM_CH) + 1;

    // A transfer happens on a clk edge where cfg_valid && cfg_ready. The master
    // holds cfg_ch/cfg_half stable while cfg_valid is high. cfg_ready is a
    // combinational function of cfg_ch and may change when cfg_ch changes.
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic            cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clock_div_multi.sv
// NUM_CH independent clock dividers with glitch-free half-period reload and clean stop.
// Optional macro CLOCK_DIV_SYNC_EN adds sync_req to realign all running channels.
module clock_div_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic              sync_req,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    clock_div_multi_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);
    localparam int CH_W = $clog2(NUM_CH) + 1;
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic busy_sel;
    logic ch_valid;
    logic accept;

    // Out-of-range indices never match, so they read as not busy (always ready).
    always_comb begin
        busy_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) busy_sel = busy[i];
        end
    end

    assign ch_valid      = cfg.cfg_ch < CH_W'(NUM_CH);
    assign cfg.cfg_ready = !busy_sel;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) cfg.cfg_err <= 1'b0;
        else     cfg.cfg_err <= accept && !ch_valid;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half_act;
        logic [CNT_W-1:0] half_pend;
        logic             out_q;
        logic             tick_q;
        logic             busy_q;
        logic             wr_hit;
        logic             run;
        logic             at_end;
        logic             apply;
        logic             sync_hit;

        assign wr_hit = accept && (cfg.cfg_ch == CH_W'(g));
        // A high phase always runs to completion, even after ch_en drops.
        assign run    = (ch_en[g] || out_q) && (half_act != '0);
        assign at_end = cnt == (half_act - CNT_W'(1));
        assign apply  = busy_q && ((run && out_q && at_end) ||
                                   (!ch_en[g] && !out_q) ||
                                   (half_act == '0));
`ifdef CLOCK_DIV_SYNC_EN
        assign sync_hit = sync_req && ch_en[g] && (half_act != '0);
`else
        assign sync_hit = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                out_q     <= 1'b0;
                tick_q    <= 1'b0;
                busy_q    <= 1'b0;
                half_act  <= RST_HALF;
                half_pend <= RST_HALF;
            end else begin
                tick_q <= 1'b0;
                if (sync_hit) begin
                    cnt   <= '0;
                    out_q <= 1'b0;
                end else if (run) begin
                    if (at_end) begin
                        cnt    <= '0;
                        out_q  <= !out_q;
                        tick_q <= !out_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end

                // wr_hit needs busy_q=0 and apply needs busy_q=1, so they never collide.
                if (wr_hit) begin
                    half_pend <= cfg.cfg_half;
                    busy_q    <= 1'b1;
                end else if (apply || (sync_hit && busy_q)) begin
                    half_act <= half_pend;
                    busy_q   <= 1'b0;
                end
            end
        end

        assign clk_out[g] = out_q;
        assign tick[g]    = tick_q;
        assign busy[g]    = busy_q;
    end
endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi (NUM_CH=4, CNT_W=16, DEFAULT_HALF=1).
// Define CLOCK_DIV_SYNC_EN to also exercise sync_req.
module tb_clock_div_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
  logic              sync_req;

  int n_vec;
  int n_err;

  clock_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  clock_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(1)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CLOCK_DIV_SYNC_EN
    .sync_req(sync_req),
`endif
    .ch_en   (ch_en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int half);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_half  = 16'(half);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    ch_en = '0;
    sync_req = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_half = '0;
    cyc(3);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_if.cfg_err, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;

    // half=1 default: clk/2 with a tick on every rise
    ch_en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("t1_out", clk_out[0], k % 2);
      chk("t1_tick", tick[0], k % 2);
    end
    ch_en = 4'b0000;
    cyc(1);
    cfg_write(0, 3);
    #1;
    chk("t2_ready", cfg_if.cfg_ready, 1);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("t2_busy_idle", busy, 4'b0001);
    cyc(1);
    chk("t2_applied_idle", busy, 0);

    // half=3 running, reload to 5 during the high phase
    ch_en = 4'b0001;
    cyc(3);
    chk("t2_rise1", clk_out[0], 1);
    chk("t2_tick1", tick[0], 1);
    cyc(1);
    chk("t2_high", clk_out[0], 1);
    chk("t2_tick_once", tick[0], 0);
    cfg_write(0, 5);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("t2_busy", busy[0], 1);
    chk("t2_still_high", clk_out[0], 1);
    cyc(1);
    chk("t2_fall", clk_out[0], 0);
    chk("t2_busy_clr", busy[0], 0);
    cyc(4);
    chk("t2_low5", clk_out[0], 0);
    cyc(1);
    chk("t2_rise2", clk_out[0], 1);
    chk("t2_tick2", tick[0], 1);
    cyc(4);
    chk("t2_high5", clk_out[0], 1);
    cyc(1);
    chk("t2_fall2", clk_out[0], 0);
    cyc(4);
    chk("t2_low5b", clk_out[0], 0);
    cyc(1);
    chk("t2_rise3", clk_out[0], 1);
    chk("t2_tick3", tick[0], 1);

    // ch1 half=4, enable dropped one cycle into the high phase
    ch_en = 4'b0000;
    cfg_write(1, 4);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    cyc(1);
    chk("t3_busy", busy[1], 0);
    ch_en = 4'b0010;
    cyc(3);
    chk("t3_low", clk_out[1], 0);
    cyc(1);
    chk("t3_rise", clk_out[1], 1);
    chk("t3_tick", tick[1], 1);
    ch_en = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk("t3_hold_high", clk_out[1], 1);
      chk("t3_no_tick_h", tick[1], 0);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("t3_parked", clk_out[1], 0);
      chk("t3_no_tick_l", tick[1], 0);
    end

    // invalid channel index
    cfg_write(7, 9);
    #1;
    chk("t4_ready_bad", cfg_if.cfg_ready, 1);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("t4_err", cfg_if.cfg_err, 1);
    chk("t4_no_busy", busy, 0);
    cyc(1);
    chk("t4_err_pulse", cfg_if.cfg_err, 0);

    // half=0 parks ch2 low; reload from 0 applies at once
    cfg_write(2, 0);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("t4_busy2", busy[2], 1);
    cyc(1);
    chk("t4_busy2_clr", busy[2], 0);
    ch_en = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("t4_park_out", clk_out[2], 0);
      chk("t4_park_tick", tick[2], 0);
    end
    cfg_write(2, 2);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    #1;
    chk("t4_busy_h0", busy[2], 1);
    chk("t4_not_ready", cfg_if.cfg_ready, 0);
    cyc(1);
    chk("t4_apply_h0", busy[2], 0);
    cyc(1);
    chk("t4_h2_low", clk_out[2], 0);
    cyc(1);
    chk("t4_h2_rise", clk_out[2], 1);
    chk("t4_h2_tick", tick[2], 1);

    // reset while busy and high
    cfg_write(2, 7);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("t5_busy", busy[2], 1);
    chk("t5_high", clk_out[2], 1);
    rst = 1'b1;
    ch_en = 4'b0000;
    cyc(1);
    chk("t5_clk_out", clk_out, 0);
    chk("t5_tick", tick, 0);
    chk("t5_busy_clr", busy, 0);
    chk("t5_err", cfg_if.cfg_err, 0);
    rst = 1'b0;
    ch_en = 4'b0100;
    cyc(1);
    chk("t5_def_rise", clk_out[2], 1);
    chk("t5_def_tick", tick[2], 1);
    cyc(1);
    chk("t5_def_fall", clk_out[2], 0);
    cyc(1);
    chk("t5_def_rise2", clk_out[2], 1);

`ifdef CLOCK_DIV_SYNC_EN
    // halves 2,3,4 realigned by sync_req
    ch_en = 4'b0000;
    cyc(3);
    for (int c = 0; c < 3; c++) begin
      cfg_write(c, c + 2);
      cyc(1);
      cfg_if.cfg_valid = 1'b0;
      cyc(1);
    end
    cyc(2);
    chk("t6_loaded", busy, 0);
    ch_en = 4'b0111;
    cyc(5);
    sync_req = 1'b1;
    cyc(1);
    sync_req = 1'b0;
    chk("t6_sync_low", clk_out, 0);
    for (int j = 1; j <= 12; j++) begin
      cyc(1);
      chk("t6_tick0", tick[0], (j >= 2 && (j - 2) % 4 == 0) ? 1 : 0);
      chk("t6_tick1", tick[1], (j >= 3 && (j - 3) % 6 == 0) ? 1 : 0);
      chk("t6_tick2", tick[2], (j >= 4 && (j - 4) % 8 == 0) ? 1 : 0);
    end
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
